fifo_rd_stream: RTL and testbench

- Read-side consumer for the async_fifo read port, in the rd_clk domain.
- Pops words from the FIFO using its read interface (rd_en, rd_data, empty) and presents them downstream as a valid/ready stream.
- Hides the FIFO's 1-cycle read latency behind a 2-entry skid buffer, so a continuously-ready sink gets one word per cycle.
- Provides a flush and an optional delivered-word counter.

---
 rtl/fifo_rd_stream.sv | 159 +++++++++++++++
 tb/tb_fifo_rd_stream.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for the async_fifo read port (rd_clk domain).
// Pops words through the FIFO read interface and presents them downstream as a
// valid/ready stream. A 2-entry skid buffer hides the FIFO's 1-cycle read
// latency, so a sink that is always ready receives one word per cycle.
//
// Optional feature: define FIFO_RD_COUNT_EN to build a saturating
// delivered-word counter on rd_count. When it is undefined, rd_count is tied
// to zero and no counter logic exists.
//
// Handshake: a word transfers on a rising edge where m_valid=1 and m_ready=1.
// Once m_valid is high, m_data is held stable until that transfer happens.
// m_valid never depends combinationally on m_ready.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  // Number of entries held in the skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Complete control state; checkers can bind to st.occ / st.inflight.
  typedef struct packed {
    occ_e occ;       // entries buffered
    logic inflight;  // a pop was issued last cycle; its data arrives now
  } rd_state_t;

  rd_state_t             st;
  rd_state_t             st_next;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_next;
  logic                  pop;
  logic [1:0]            occ_cnt;
  logic [2:0]            committed;

  assign m_valid = (st.occ == ONE) || (st.occ == TWO);
  assign m_data  = head;
  assign pop     = m_valid & m_ready;

  // Occupancy as a number; an illegal encoding counts as full so that no
  // further pops are issued while it recovers.
  always_comb begin
    occ_cnt = 2'd2;
    case (st.occ)
      EMPTY:   occ_cnt = 2'd0;
      ONE:     occ_cnt = 2'd1;
      TWO:     occ_cnt = 2'd2;
      default: occ_cnt = 2'd2;
    endcase
  end

  // Words that will still be buffered after this edge (including an arrival).
  // A new pop is only allowed while that leaves room for one more word, so
  // buffered plus in-flight never exceeds two.
  always_comb begin
    committed  = {1'b0, occ_cnt} + {2'b00, st.inflight} - {2'b00, pop};
    fifo_rd_en = rd_rst_n & ~flush & ~fifo_empty & (committed <= 3'd1);
  end

  // Next-state: arrivals land behind whatever survives this cycle's pop.
  always_comb begin
    st_next.occ      = st.occ;
    st_next.inflight = fifo_rd_en;
    head_next        = head;
    tail_next        = tail;
    if (flush) begin
      // Buffered words and any word arriving this edge are discarded.
      st_next.occ      = EMPTY;
      st_next.inflight = 1'b0;
    end else begin
      case (st.occ)
        EMPTY: begin
          if (st.inflight) begin
            head_next   = fifo_rd_data;
            st_next.occ = ONE;
          end
        end
        ONE: begin
          case ({pop, st.inflight})
            2'b10: st_next.occ = EMPTY;
            2'b01: begin
              tail_next   = fifo_rd_data;
              st_next.occ = TWO;
            end
            2'b11: head_next = fifo_rd_data;  // replace popped head, stay ONE
            default: ;
          endcase
        end
        TWO: begin
          // With two buffered, no pop can have been issued last cycle unless
          // the sink popped then, so an arrival here always pairs with a pop.
          if (pop) begin
            head_next   = tail;
            st_next.occ = ONE;
            if (st.inflight) begin
              tail_next   = fifo_rd_data;
              st_next.occ = TWO;
            end
          end
        end
        default: begin
          st_next.occ      = EMPTY;
          st_next.inflight = 1'b0;
        end
      endcase
    end
  end

  // State and buffer registers with synchronous active-low reset.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      st.occ      <= EMPTY;
      st.inflight <= 1'b0;
      head        <= '0;
      tail        <= '0;
    end else begin
      st   <= st_next;
      head <= head_next;
      tail <= tail_next;
    end
  end

`ifdef FIFO_RD_COUNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q;

  // Saturating count of delivered words; flush does not clear it.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      cnt_q <= '0;
    end else if (pop && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: directed vector table, hand-written flush and
// reset sequences, and randomized traffic checked against a queue-based model.
module tb_fifo_rd_stream;

  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rd_rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] rd_count;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk       (clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .rd_count     (rd_count)
  );

  // ---------------- environment and reference model ----------------
  logic [DW-1:0] fifo_q[$];   // words still in the upstream FIFO
  logic [DW-1:0] pend_w;      // word popped last cycle, shown on fifo_rd_data next
  bit            pend_v;
  logic [DW-1:0] buf_q[$];    // words the stream should currently hold, head first
  bit            infl_m;      // a popped word is on its way in
  logic [DW-1:0] infl_w;
  int            cnt_m;       // words delivered since reset (saturating)
  logic [DW-1:0] exp_q[$];    // scoreboard: delivery order expected by the sink
  int            n_deliv;

  // Values sampled in the last step.
  bit            s_valid;
  bit            s_en;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_cnt;

  int n_chk;
  int n_err;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_cnt(input int c);
`ifdef FIFO_RD_COUNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // compare against the model, then advance the model across the rising edge.
  task automatic step(input bit rdy, input bit fl, input bit rst);
    logic [DW-1:0] w;
    bit            exp_valid;
    bit            pop_m;
    bit            exp_en;
    int            left;
    w          = '0;
    m_ready    = rdy;
    flush      = fl;
    rd_rst_n   = rst;
    fifo_empty = (fifo_q.size() == 0);
    if (pend_v) begin
      fifo_rd_data = pend_w;
      pend_v       = 1'b0;
    end
    #1;
    s_valid = m_valid;
    s_data  = m_data;
    s_en    = fifo_rd_en;
    s_cnt   = rd_count;

    exp_valid = (buf_q.size() != 0);
    pop_m     = exp_valid && rdy;
    left      = buf_q.size() + int'(infl_m) - int'(pop_m);
    exp_en    = rst && !fl && (fifo_q.size() != 0) && (left <= 1);

    chk("m_valid", s_valid, exp_valid);
    if (exp_valid) chk("m_data", s_data, buf_q[0]);
    chk("fifo_rd_en", s_en, exp_en);
    chk("rd_count", s_cnt, exp_cnt(cnt_m));
    chk("rd_en_while_empty", s_en && fifo_empty, 1'b0);

    if (pop_m && rst) begin
      chk("sink_expected_word", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("delivery_order", s_data, exp_q.pop_front());
      n_deliv++;
    end

    if (s_en && fifo_q.size() != 0) begin
      w      = fifo_q.pop_front();
      pend_w = w;
      pend_v = 1'b1;
    end

    if (!rst) begin
      buf_q.delete();
      infl_m = 1'b0;
      cnt_m  = 0;
      exp_q  = fifo_q;
    end else begin
      if (pop_m && cnt_m < CNT_MAX) cnt_m++;
      if (fl) begin
        buf_q.delete();
        infl_m = 1'b0;
        exp_q  = fifo_q;
      end else begin
        if (pop_m) void'(buf_q.pop_front());
        if (infl_m) buf_q.push_back(infl_w);
        infl_m = s_en;
        infl_w = w;
      end
    end
    chk("occupancy_le_2", (buf_q.size() + int'(infl_m)) <= 2, 1'b1);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            rdy;
    bit            push;
    logic [DW-1:0] push_w;
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    bit            exp_en;
    int            exp_cnt;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int            d0;
    int            n_en;
    int            idx;
    logic [CW-1:0] cnt_before;
    logic [DW-1:0] first_w;
    bit            got;

    n_chk = 0; n_err = 0; n_deliv = 0;
    cnt_m = 0; pend_v = 1'b0; infl_m = 1'b0;
    pend_w = '0; infl_w = '0;
    rd_rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0;

    // Stream after reset (rows 0..12), then a single lone word (rows 13..17).
    for (int k = 0; k < 13; k++) begin
      vecs[k].rdy       = 1'b1;
      vecs[k].push      = 1'b0;
      vecs[k].push_w    = '0;
      vecs[k].exp_en    = (k <= 9);
      vecs[k].exp_valid = (k >= 2) && (k <= 11);
      vecs[k].exp_data  = DW'(k - 1);
      vecs[k].exp_cnt   = (k >= 2) ? k - 2 : 0;
    end
    vecs[13] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 10};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 10};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 10};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 11};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 11};

    @(negedge clk);

    // Reset with words already waiting: no pops while reset is held.
    for (int i = 1; i <= 10; i++) push_word(DW'(i));
    step(1'b1, 1'b0, 1'b0);
    chk("reset_valid", s_valid, 1'b0);
    chk("reset_rd_en", s_en, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_count", s_cnt, '0);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].push) push_word(vecs[i].push_w);
      step(vecs[i].rdy, 1'b0, 1'b1);
      chk($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), s_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_rd_en", i), s_en, vecs[i].exp_en);
      chk($sformatf("vec%0d_count", i), s_cnt, exp_cnt(vecs[i].exp_cnt));
    end

    // Backpressure: only two pops, head held at 0x01.
    for (int i = 1; i <= 10; i++) push_word(DW'(i));
    n_en = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1);
      n_en += int'(s_en);
      if (s_valid) chk("bp_hold_data", s_data, 8'h01);
    end
    chk("bp_rd_en_pulses", n_en, 2);
    chk("bp_valid_held", s_valid, 1'b1);
    d0 = n_deliv;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || buf_q.size() != 0); i++)
      step(1'b1, 1'b0, 1'b1);
    chk("bp_delivered", n_deliv - d0, 10);
    chk("bp_no_loss", exp_q.size(), 0);

    // Flush with two words buffered (0x03, 0x04).
    for (int i = 1; i <= 10; i++) push_word(DW'(i));
    d0 = n_deliv;
    for (int i = 0; i < 20 && (n_deliv - d0) < 2; i++) step(1'b1, 1'b0, 1'b1);
    chk("flush_setup", n_deliv - d0, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    chk("flush_valid_before", s_valid, 1'b1);
    chk("flush_head_before", s_data, 8'h03);
    cnt_before = s_cnt;
    step(1'b0, 1'b1, 1'b1);
    chk("flush_rd_en", s_en, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("flush_valid_after", s_valid, 1'b0);
    chk("flush_count_kept", s_cnt, cnt_before);
    got = 1'b0; first_w = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (s_valid) begin
        got     = 1'b1;
        first_w = s_data;
      end
    end
    chk("flush_next_seen", got, 1'b1);
    chk("flush_next_word", first_w, 8'h05);
    for (int i = 0; i < 40 && (exp_q.size() != 0 || buf_q.size() != 0); i++)
      step(1'b1, 1'b0, 1'b1);
    chk("flush_drained", exp_q.size(), 0);

    // Random sink readiness over 200 words trickling into the FIFO.
    idx = 0;
    d0  = n_deliv;
    for (int c = 0; c < 3000 && (idx < 200 || exp_q.size() != 0 || buf_q.size() != 0); c++) begin
      if (idx < 200 && $urandom_range(0, 1) == 1) begin
        push_word(DW'(idx));
        idx++;
      end
      step($urandom_range(0, 1) == 1, 1'b0, 1'b1);
    end
    chk("rand_all_pushed", idx, 200);
    chk("rand_all_delivered", n_deliv - d0, 200);
    chk("rand_queue_empty", exp_q.size(), 0);

    // Random traffic with occasional flush (including flush during a pop).
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 1) == 1) push_word(DW'($urandom_range(0, 255)));
      step($urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0, 1'b1);
    end
    for (int i = 0; i < 400 && (exp_q.size() != 0 || buf_q.size() != 0); i++)
      step(1'b1, 1'b0, 1'b1);
    chk("rand_flush_drained", exp_q.size(), 0);

    // Counter saturation, then reset in the middle of a stream.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) push_word(DW'(8'h80 + i));
    for (int i = 0; i < 60 && (exp_q.size() != 0 || buf_q.size() != 0); i++)
      step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("sat_count", s_cnt, exp_cnt(CNT_MAX));
    for (int i = 0; i < 10; i++) push_word(DW'(8'hC0 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    chk("mid_valid_before_rst", s_valid, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("mid_rst_rd_en", s_en, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", s_valid, 1'b0);
    chk("mid_rst_count", s_cnt, '0);
    for (int i = 0; i < 40 && (exp_q.size() != 0 || buf_q.size() != 0); i++)
      step(1'b1, 1'b0, 1'b1);
    chk("mid_rst_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
